// File: rtl/corr_acc_ctrl.sv
// Accumulation-frame controller for the MSDFT correlator: turns register-bank
// controls into per-sample first/last strobes and keeps frame/miss counters.
module corr_acc_ctrl #(
  parameter int unsigned LEN_WIDTH   = 32,
  parameter int unsigned FRAME_WIDTH = 32,
  parameter int unsigned MISS_WIDTH  = 16
) (
  input  logic                   axi_clock,
  input  logic                   rst,
  input  logic                   correlator_en,
  input  logic                   correlator_rst,
  input  logic [LEN_WIDTH-1:0]   acc_len,
  input  logic                   corr_new_frame,
  input  logic                   corr_continuous,
  input  logic                   din_valid,
  output logic                   acc_valid,
  output logic                   acc_first,
  output logic                   acc_last,
  output logic                   busy,
  output logic [FRAME_WIDTH-1:0] frame_count,
  output logic [MISS_WIDTH-1:0]  miss_count
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t               state;
  logic                 pending;
  logic                 new_frame_d;
  logic [LEN_WIDTH-1:0] len_q;
  logic [LEN_WIDTH-1:0] sample_cnt;
  logic                 rise;
  logic [LEN_WIDTH-1:0] len_eff;
  logic                 clear;

  assign clear   = rst | correlator_rst;
  assign rise    = corr_new_frame & ~new_frame_d;
  assign len_eff = (acc_len == '0) ? LEN_WIDTH'(1) : acc_len;

  always_ff @(posedge axi_clock) begin
    if (clear) begin
      state       <= IDLE;
      pending     <= 1'b0;
      // Edge register starts high so a level already asserted does not arm.
      new_frame_d <= 1'b1;
      len_q       <= '0;
      sample_cnt  <= '0;
      frame_count <= '0;
      miss_count  <= '0;
      acc_valid   <= 1'b0;
      acc_first   <= 1'b0;
      acc_last    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      new_frame_d <= corr_new_frame;
      acc_valid   <= 1'b0;
      acc_first   <= 1'b0;
      acc_last    <= 1'b0;

      unique case (state)
        IDLE: begin
          if (rise)
            pending <= 1'b1;
          if (correlator_en && (corr_continuous || pending || rise)) begin
            state      <= RUN;
            busy       <= 1'b1;
            pending    <= 1'b0;
            sample_cnt <= '0;
            len_q      <= len_eff;
          end
        end

        RUN: begin
          if (rise && (miss_count != '1))
            miss_count <= miss_count + MISS_WIDTH'(1);

          if (!correlator_en) begin
            state      <= IDLE;
            busy       <= 1'b0;
            sample_cnt <= '0;
          end else if (din_valid) begin
            acc_valid <= 1'b1;
            acc_first <= (sample_cnt == '0);
            acc_last  <= (sample_cnt == len_q - LEN_WIDTH'(1));
            if (sample_cnt == len_q - LEN_WIDTH'(1)) begin
              frame_count <= frame_count + FRAME_WIDTH'(1);
              sample_cnt  <= '0;
              // Continuous restart stays in RUN so the next valid opens a frame.
              if (corr_continuous) begin
                len_q <= len_eff;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              sample_cnt <= sample_cnt + LEN_WIDTH'(1);
            end
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
